lookup_ram_upload: RTL and testbench
====================================

LOOKUP_RAM_UPLOAD -- requirements
Module: lookup_ram_upload

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, giving the number of lookup_RAM entries streamed (legal 1..16).
REQ-002 SHALL have port clk21m  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-005 SHALL have port abort  input  1  terminates any dump in progress.
REQ-006 SHALL have port tbl_index  output  4  lookup_RAM entry index being read.
REQ-007 SHALL have port tbl_rd  output  1  read strobe; data valid exactly 1 cycle later.
REQ-008 SHALL have port tbl_addr  input  27  lookup_RAM_t.addr of the read entry.
REQ-009 SHALL have port tbl_size  input  16  lookup_RAM_t.size of the read entry.
REQ-010 SHALL have port tbl_ro  input  1  lookup_RAM_t.ro of the read entry.
REQ-011 SHALL have port out_data  output  8  stream byte.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the byte when out_valid is also high.
REQ-014 SHALL have port busy  output  1  high from accepted start until DONE or abort.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the checksum byte is accepted.

Function
REQ-016 SHALL emit the stream in this order: header 0xA5, count byte ENTRIES, then 6 bytes per entry from index 0 upward, then 1 checksum byte. Total length is 3+6*ENTRIES bytes.
REQ-017 SHALL emit entry bytes in this order:
- addr[7:0], addr[15:8], addr[23:16]
- {ro, 4'b0000, addr[26:24]}
- size[7:0], size[15:8]
REQ-018 SHALL compute the checksum as the two's complement of the 8-bit modulo-256 sum of all preceding bytes, including header and count, so that the sum of all bytes mod 256 equals 0.
REQ-019 SHALL implement states IDLE, HDR, CNT, FETCH, WAIT, SEND, CKSUM, DONE.
REQ-020 SHALL transition IDLE -> HDR on start; start SHALL be ignored while busy=1.
REQ-021 SHALL transition HDR -> CNT -> FETCH, each on a byte handshake (out_valid && out_ready).
REQ-022 In FETCH, SHALL pulse tbl_rd for one cycle with tbl_index = current entry, then enter WAIT.
REQ-023 In WAIT, SHALL latch tbl_addr/tbl_size/tbl_ro into an internal 48-bit shadow register, then enter SEND with byte counter 0.
REQ-024 In SEND, SHALL advance the byte counter on each handshake.
- After byte 5 of entry i<ENTRIES-1: FETCH with entry i+1.
- After byte 5 of the last entry: CKSUM.
REQ-025 SHALL transition CKSUM -> DONE on handshake; DONE SHALL pulse done for one cycle, then enter IDLE.
REQ-026 SHALL hold out_valid low in IDLE, FETCH, WAIT and DONE, and high in HDR, CNT, SEND and CKSUM.
REQ-027 SHALL hold out_data stable while out_valid=1 and out_ready=0; the shadow register SHALL make table input changes during a stall invisible.
REQ-028 SHALL accept back-to-back handshakes: with out_ready held at 1, one byte per cycle inside HDR/CNT/SEND/CKSUM, plus 2 idle cycles (FETCH, WAIT) per entry.
REQ-029 SHALL update the checksum accumulator only on a handshake, and SHALL clear it when a start is accepted.
REQ-030 abort SHALL take priority over every other event, including a same-cycle handshake or start. In the next cycle: state IDLE, out_valid=0, busy=0, done not pulsed.
REQ-031 SHALL, when start and a done pulse coincide, ignore start; a new start is honoured from IDLE only.

Reset
REQ-032 With reset_n=0 at a clock edge, SHALL enter IDLE and drive out_valid=0, out_data=0x00, tbl_rd=0, tbl_index=0, busy=0 and done=0. The byte counter, entry counter and checksum SHALL be cleared.
REQ-033 SHALL give reset the same priority as abort when it is asserted mid-dump; no done pulse.

Verification
REQ-034 ENTRIES=1, entry addr=27'h1234567, size=16'h0040, ro=1, out_ready=1 -> stream A5 01 67 45 23 81 40 00 CA, one done pulse, busy low afterwards.
REQ-035 ENTRIES=16, all entries zero, out_ready=1 -> 99 bytes: A5, 10, 96x00, checksum 0x4B. Total cycles from start to done = 99 + 32 idle + 1.
REQ-036 Random out_ready stalls; tbl_* inputs toggled while stalled -> out_data unchanged during each stall, and the byte sequence is identical to REQ-034.
REQ-037 abort asserted during SEND byte 3 of entry 2 -> next cycle out_valid=0, busy=0, no done. A following start restarts with 0xA5 and a fresh checksum.
REQ-038 start pulsed while busy, and start coincident with done -> both ignored; exactly one stream produced.
REQ-039 reset_n low for 1 cycle mid-CKSUM -> all outputs at REQ-032 values on the next cycle; no done pulse.

Source files
------------

// File: rtl/lookup_ram_upload.sv
// Streams the lookup_RAM table as a framed byte stream: header, entry count,
// six bytes per entry and a closing two's-complement checksum.
module lookup_ram_upload #(
  parameter int ENTRIES = 16
) (
  input  logic        clk21m,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  tbl_index,
  output logic        tbl_rd,
  input  logic [26:0] tbl_addr,
  input  logic [15:0] tbl_size,
  input  logic        tbl_ro,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, HDR, CNT, FETCH, WAIT, SEND, CKSUM, DONE
  } state_t;

  localparam logic [7:0] HEADER     = 8'hA5;
  localparam logic [7:0] COUNT_BYTE = 8'(ENTRIES);
  localparam logic [3:0] LAST_ENTRY = 4'(ENTRIES - 1);

  state_t      state_q, state_d;
  logic [3:0]  entry_q;
  logic [2:0]  byte_q;
  logic [7:0]  cksum_q;
  logic [47:0] shadow_q;
  logic        handshake;

  assign handshake = out_valid && out_ready;
  assign tbl_rd    = (state_q == FETCH);
  assign tbl_index = entry_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = 8'h00;
    unique case (state_q)
      IDLE:  if (start) state_d = HDR;
      HDR: begin
        out_valid = 1'b1;
        out_data  = HEADER;
        if (out_ready) state_d = CNT;
      end
      CNT: begin
        out_valid = 1'b1;
        out_data  = COUNT_BYTE;
        if (out_ready) state_d = FETCH;
      end
      FETCH: state_d = WAIT;
      WAIT:  state_d = SEND;
      SEND: begin
        out_valid = 1'b1;
        case (byte_q)
          3'd0:    out_data = shadow_q[7:0];
          3'd1:    out_data = shadow_q[15:8];
          3'd2:    out_data = shadow_q[23:16];
          3'd3:    out_data = shadow_q[31:24];
          3'd4:    out_data = shadow_q[39:32];
          default: out_data = shadow_q[47:40];
        endcase
        if (out_ready && byte_q == 3'd5)
          state_d = (entry_q == LAST_ENTRY) ? CKSUM : FETCH;
      end
      CKSUM: begin
        out_valid = 1'b1;
        out_data  = ~cksum_q + 8'd1;
        if (out_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort outranks start, handshakes and the final transition to DONE.
    if (abort) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk21m) begin
    if (!reset_n) begin
      state_q <= IDLE;
      entry_q <= 4'd0;
      byte_q  <= 3'd0;
      cksum_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (!abort) begin
        if (state_q == IDLE && start) begin
          entry_q <= 4'd0;
          byte_q  <= 3'd0;
          cksum_q <= 8'd0;
        end
        if (handshake) cksum_q <= cksum_q + out_data;
        if (state_q == WAIT) byte_q <= 3'd0;
        if (state_q == SEND && out_ready) begin
          if (byte_q == 3'd5) begin
            byte_q <= 3'd0;
            if (entry_q != LAST_ENTRY) entry_q <= entry_q + 4'd1;
          end else begin
            byte_q <= byte_q + 3'd1;
          end
        end
      end
    end
  end

  // NOTE: the shadow is pure data, always reloaded in WAIT before it is
  // read, so it carries no reset.
  always_ff @(posedge clk21m) begin
    if (state_q == WAIT)
      shadow_q <= {tbl_size, tbl_ro, 4'b0000, tbl_addr};
  end

endmodule

// File: tb/tb_lookup_ram_upload.sv
// Directed bench: one single-entry and one full-table instance, each fed by a
// one-cycle-latency table model that drives noise outside the valid cycle.
module tb_lookup_ram_upload;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, abort, out_ready, start1, start16;
  logic [3:0]  idx1, idx16;
  logic        rd1, rd16, ro1, ro16;
  logic [26:0] addr1, addr16;
  logic [15:0] size1, size16;
  logic [7:0]  data1, data16;
  logic        valid1, valid16, busy1, busy16, done1, done16;

  lookup_ram_upload #(.ENTRIES(1)) u_dut1 (
    .clk21m(clk), .reset_n(reset_n), .start(start1), .abort(abort),
    .tbl_index(idx1), .tbl_rd(rd1), .tbl_addr(addr1), .tbl_size(size1),
    .tbl_ro(ro1), .out_data(data1), .out_valid(valid1), .out_ready(out_ready),
    .busy(busy1), .done(done1));

  lookup_ram_upload u_dut16 (
    .clk21m(clk), .reset_n(reset_n), .start(start16), .abort(abort),
    .tbl_index(idx16), .tbl_rd(rd16), .tbl_addr(addr16), .tbl_size(size16),
    .tbl_ro(ro16), .out_data(data16), .out_valid(valid16), .out_ready(out_ready),
    .busy(busy16), .done(done16));

  // Table models: real data only in the cycle after tbl_rd, noise otherwise.
  logic [26:0] mem_addr [16];
  logic [15:0] mem_size [16];
  logic        mem_ro   [16];
  logic        rq1, rq16;
  logic [3:0]  iq16;
  logic [26:0] n_addr;
  logic [15:0] n_size;
  logic        n_ro;

  always @(posedge clk) begin
    rq1  <= rd1;
    rq16 <= rd16;
    iq16 <= idx16;
  end
  always @(negedge clk) begin
    n_addr <= 27'($urandom);
    n_size <= 16'($urandom);
    n_ro   <= 1'($urandom);
  end

  assign addr1  = rq1 ? 27'h1234567 : n_addr;
  assign size1  = rq1 ? 16'h0040 : n_size;
  assign ro1    = rq1 ? 1'b1 : n_ro;
  assign addr16 = rq16 ? mem_addr[iq16] : n_addr;
  assign size16 = rq16 ? mem_size[iq16] : n_size;
  assign ro16   = rq16 ? mem_ro[iq16] : n_ro;

  logic sel;
  wire [7:0] data  = sel ? data16 : data1;
  wire       valid = sel ? valid16 : valid1;
  wire       busy  = sel ? busy16 : busy1;
  wire       done  = sel ? done16 : done1;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int n_cyc, n_done;
  logic [7:0] exp34 [9] = '{8'hA5, 8'h01, 8'h67, 8'h45, 8'h23, 8'h81, 8'h40, 8'h00, 8'hCA};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start16 = v; else start1 = v;
  endtask

  // Leaves the bench at the negedge after the accepting edge.
  task automatic pulse_start();
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    start1  = 1'b0;
    start16 = 1'b0;
  endtask

  // Collects bytes until done; n_cyc counts edges including the start edge.
  task automatic collect(input bit rnd, input bit poke);
    logic [7:0] prev;
    bit stalled;
    got.delete();
    n_cyc = 1; n_done = 0; stalled = 0; prev = 8'h00;
    while (n_cyc < 2000) begin
      set_start(poke && n_cyc == 4);
      if (stalled) begin
        check("stall_valid", valid, 1);
        check("stall_data", data, prev);
      end
      if (done) begin
        n_done++;
        if (poke) set_start(1'b1);
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid && out_ready) got.push_back(data);
      stalled = valid && !out_ready;
      prev = data;
      @(negedge clk);
      n_cyc++;
    end
    check("done_seen", n_done, 1);
  endtask

  // Runs with out_ready=1 until byte k is presented (not yet accepted).
  task automatic run_until(input int k);
    int guard = 0;
    out_ready = 1'b1;
    got.delete();
    while (!(valid && got.size() == k) && guard < 500) begin
      if (valid) got.push_back(data);
      @(negedge clk);
      guard++;
    end
    check("reach_byte", got.size(), k);
  endtask

  function automatic void build_exp16();
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mem_addr[i][7:0]);
      exp_q.push_back(mem_addr[i][15:8]);
      exp_q.push_back(mem_addr[i][23:16]);
      exp_q.push_back({mem_ro[i], 4'b0000, mem_addr[i][26:24]});
      exp_q.push_back(mem_size[i][7:0]);
      exp_q.push_back(mem_size[i][15:8]);
    end
    s = 8'h00;
    foreach (exp_q[j]) s = s + exp_q[j];
    exp_q.push_back(~s + 8'd1);
  endfunction

  task automatic quiet_cycles(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      if (done || valid || busy) hits++;
      @(negedge clk);
    end
    check(tag, hits, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset_n = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; start16 = 1'b0; sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_addr[i] = 27'h0; mem_size[i] = 16'h0; mem_ro[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_valid", {valid1, valid16}, 0);
    check("rst_data", {data1, data16}, 0);
    check("rst_rd", {rd1, rd16}, 0);
    check("rst_index", {idx1, idx16}, 0);
    check("rst_busy", {busy1, busy16}, 0);
    check("rst_done", {done1, done16}, 0);
    reset_n = 1'b1;

    // Single entry, free-flowing consumer.
    sel = 1'b0;
    pulse_start();
    collect(1'b0, 1'b0);
    check("e1_len", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) check("e1_byte", got[i], exp34[i]);
    @(negedge clk);
    check("e1_done_pulse", done, 0);
    check("e1_busy_after", busy, 0);

    // Full table of zeros: length, checksum and cycle count.
    sel = 1'b1;
    pulse_start();
    collect(1'b0, 1'b0);
    check("e16_len", got.size(), 99);
    check("e16_cycles", n_cyc, 132);
    if (got.size() == 99) begin
      check("e16_hdr", got[0], 8'hA5);
      check("e16_cnt", got[1], 8'h10);
      bad = 0;
      for (int i = 2; i < 98; i++) if (got[i] != 8'h00) bad++;
      check("e16_zero_body", bad, 0);
      check("e16_cksum", got[98], 8'h4B);
    end
    @(negedge clk);

    // Random stalls with table noise: same single-entry stream.
    sel = 1'b0;
    pulse_start();
    collect(1'b1, 1'b0);
    check("stall_len", got.size(), 9);
    bad = 0;
    for (int i = 0; i < 9 && i < got.size(); i++) if (got[i] != exp34[i]) bad++;
    check("stall_seq", bad, 0);
    @(negedge clk);

    // Abort on entry 2 byte 3 with a coincident handshake, then restart.
    sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_addr[i] = 27'(i * 32'h0913_5A7 + 32'h5);
      mem_size[i] = 16'(i * 32'h1111 + 3);
      mem_ro[i]   = 1'(i);
    end
    build_exp16();
    pulse_start();
    run_until(17);
    check("abort_byte", data, exp_q[17]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    quiet_cycles("abort_quiet", 5);
    pulse_start();
    collect(1'b0, 1'b0);
    check("restart_len", got.size(), 99);
    if (got.size() == 99) begin
      check("restart_hdr", got[0], 8'hA5);
      bad = 0;
      for (int i = 0; i < 99; i++) if (got[i] != exp_q[i]) bad++;
      check("restart_seq", bad, 0);
      check("restart_cksum", got[98], exp_q[98]);
    end
    @(negedge clk);

    // Start while busy and start coincident with done are both ignored.
    sel = 1'b0;
    pulse_start();
    collect(1'b0, 1'b1);
    @(negedge clk);
    start1 = 1'b0;
    check("ign_len", got.size(), 9);
    check("ign_done_count", n_done, 1);
    quiet_cycles("ign_no_restart", 6);

    // Reset pulse while the checksum byte is presented.
    pulse_start();
    run_until(8);
    check("ck_byte", data, 8'hCA);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_valid", valid1, 0);
    check("mid_rst_data", data1, 0);
    check("mid_rst_rd", rd1, 0);
    check("mid_rst_index", idx1, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_done", done1, 0);
    quiet_cycles("mid_rst_quiet", 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
